// File: rtl/seg7_reader.sv
// Recovers a hex nibble from an active-low a..g segment bus. A pattern is reported
// once after it has been stable for STABLE_CYCLES cycles, through a valid/ready holding register.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:6] seg,
    output logic [3:0] value,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic       overrun,
    input  logic       ovr_clr
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_QUAL = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [0:6]     BLANK    = 7'b1111111;

    localparam logic [0:0] ST_TRACK  = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:6]    seg_m_q;
    logic [0:6]    seg_s_q;
    logic [0:6]    last_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic [3:0]    value_q, value_d;
    logic          out_valid_q, out_valid_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;

    logic          code_legal;
    logic [3:0]    code_nib;
    logic          is_blank;
    logic          same;
    logic          qualify;
    logic          offer;
    logic          transfer;

    // Literal bit 0 (leftmost) lines up with seg_s_q[0], i.e. segment a.
    always_comb begin
        code_legal = 1'b1;
        code_nib   = 4'h0;
        case (seg_s_q)
            7'b0000001: code_nib = 4'h0;
            7'b1001111: code_nib = 4'h1;
            7'b0010010: code_nib = 4'h2;
            7'b0000110: code_nib = 4'h3;
            7'b1001100: code_nib = 4'h4;
            7'b0100100: code_nib = 4'h5;
            7'b0100000: code_nib = 4'h6;
            7'b0001101: code_nib = 4'h7;
            7'b0000000: code_nib = 4'h8;
            7'b0000100: code_nib = 4'h9;
            7'b0001000: code_nib = 4'hA;
            7'b1100000: code_nib = 4'hB;
            7'b0110001: code_nib = 4'hC;
            7'b1000010: code_nib = 4'hD;
            7'b0110000: code_nib = 4'hE;
            7'b0111000: code_nib = 4'hF;
            default:    code_legal = 1'b0;
        endcase
    end

    always_comb begin
        is_blank = (seg_s_q == BLANK);
        same     = (seg_s_q == last_q);
        qualify  = same && (cnt_q == CNT_QUAL) && (state_q == ST_TRACK);
        offer    = qualify && code_legal;
        transfer = out_valid_q && out_ready;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        state_d = state_q;
        case (state_q)
            ST_TRACK:  if (qualify) state_d = ST_LOCKED;
            ST_LOCKED: if (!same)   state_d = ST_TRACK;
            default:   state_d = ST_TRACK;
        endcase
    end

    // A new result may replace the held one only if the slot is empty or draining this cycle.
    always_comb begin
        value_d     = value_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        err_d       = qualify && !code_legal && !is_blank;

        if (offer && (!out_valid_q || transfer)) begin
            value_d     = code_nib;
            out_valid_d = 1'b1;
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end

        if (offer && out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m_q     <= BLANK;
            seg_s_q     <= BLANK;
            last_q      <= BLANK;
            cnt_q       <= '0;
            state_q     <= ST_TRACK;
            value_q     <= 4'h0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            seg_m_q     <= seg;
            seg_s_q     <= seg_m_q;
            last_q      <= seg_s_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            value_q     <= value_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign value     = value_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed sequences, a vector table and a random run
// checked every cycle against a run-length based reference model.
module tb_seg7_reader;

    localparam int S = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seg_drv = BLANK;
    logic [3:0] value;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       err;
    logic       overrun;
    logic       ovr_clr = 1'b0;

    seg7_reader #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg_drv),
        .value     (value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    // Written a..g left to right; bit 6 of each entry is segment a.
    logic [6:0] code_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int checks = 0;
    int errors = 0;

    // Reference model: a run of S+1 equal samples produces its event two edges later.
    int         pend_kind [2];
    logic [3:0] pend_nib  [2];
    logic [6:0] prev_s;
    int         runlen;
    logic       m_valid, m_err, m_ovr;
    logic [3:0] m_value;
    int         edge_no;

    int         obs_valid, obs_err;
    logic [3:0] obs_value;

    // 1 = legal code, 2 = blank, 3 = unrecognised
    function automatic int classify(input logic [6:0] s, output logic [3:0] nib);
        nib = 4'h0;
        if (s == BLANK) return 2;
        for (int i = 0; i < 16; i++) begin
            if (code_tab[i] == s) begin
                nib = 4'(i);
                return 1;
            end
        end
        return 3;
    endfunction

    task automatic model_reset();
        pend_kind[0] = 0;
        pend_kind[1] = 0;
        pend_nib[0]  = 4'h0;
        pend_nib[1]  = 4'h0;
        prev_s  = BLANK;
        runlen  = 1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        m_value = 4'h0;
        edge_no = 0;
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic rdy, input logic clr);
        logic       offer, xfer, old_valid;
        logic [3:0] nib;
        logic [3:0] new_nib;
        seg_drv   = s;
        out_ready = rdy;
        ovr_clr   = clr;
        @(posedge clk);
        edge_no++;
        offer = (pend_kind[0] == 1);
        nib   = pend_nib[0];
        m_err = (pend_kind[0] == 3);
        pend_kind[0] = pend_kind[1];
        pend_nib[0]  = pend_nib[1];
        if (s == prev_s) runlen++;
        else             runlen = 1;
        prev_s = s;
        pend_kind[1] = 0;
        if (runlen == S + 1) begin
            pend_kind[1] = classify(s, new_nib);
            pend_nib[1]  = new_nib;
        end
        old_valid = m_valid;
        xfer      = old_valid && rdy;
        if (offer && (!old_valid || xfer)) begin
            m_value = nib;
            m_valid = 1'b1;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        if (offer && old_valid && !rdy) m_ovr = 1'b1;
        else if (clr)                   m_ovr = 1'b0;
        #1;
        checks++;
        if ({value, out_valid, err, overrun} !== {m_value, m_valid, m_err, m_ovr}) begin
            errors++;
            $display("FAIL model edge=%0d seg=%b: got value=%h valid=%b err=%b ovr=%b, expected value=%h valid=%b err=%b ovr=%b",
                     edge_no, s, value, out_valid, err, overrun, m_value, m_valid, m_err, m_ovr);
        end
        if (out_valid) begin
            obs_valid++;
            obs_value = value;
        end
        if (err) obs_err++;
    endtask

    task automatic hold(input logic [6:0] s, input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(s, rdy, 1'b0);
    endtask

    task automatic do_reset(input logic [6:0] s);
        seg_drv = s;
        rst_n   = 1'b0;
        #1;
        expect_eq("reset_outputs", int'({value, out_valid, err, overrun}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic latency_run(input logic [6:0] s, input string name, input int exp_val);
        int first;
        int nval;
        logic [3:0] vseen;
        first = -1;
        nval  = 0;
        vseen = 4'h0;
        for (int i = 1; i <= 20; i++) begin
            step(s, 1'b1, 1'b0);
            if (out_valid) begin
                nval++;
                vseen = value;
                if (first < 0) first = i;
            end
        end
        expect_eq({name, "_first_edge"}, first, S + 3);
        expect_eq({name, "_report_count"}, nval, 1);
        expect_eq({name, "_value"}, int'(vseen), exp_val);
        $display("%s: first report after edge %0d, value=%h, reports=%0d", name, first, vseen, nval);
    endtask

    typedef struct {
        logic [6:0] pat;
        int         hold_cycles;
        int         exp_reports;
        int         exp_errs;
        logic [3:0] exp_value;
    } vec_t;

    vec_t tbl [21];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{code_tab[i], 10, 1, 0, 4'(i)};
        tbl[16] = '{7'b1010101, 10, 0, 1, 4'h0};
        tbl[17] = '{7'b0100100, 2,  0, 0, 4'h0};
        tbl[18] = '{7'b0000000, S,  0, 0, 4'h0};
        tbl[19] = '{7'b0000000, S + 1, 1, 0, 4'h8};
        tbl[20] = '{BLANK,      10, 0, 0, 4'h0};

        #2;
        do_reset(BLANK);

        // Steady 3: single report after edge S+3, none afterwards.
        latency_run(7'b0000110, "steady3", 3);

        for (int v = 0; v < 21; v++) begin
            obs_valid = 0;
            obs_err   = 0;
            obs_value = 4'h0;
            hold(tbl[v].pat, tbl[v].hold_cycles, 1'b1);
            hold(BLANK, 6, 1'b1);
            expect_eq($sformatf("vec%0d_reports", v), obs_valid, tbl[v].exp_reports);
            expect_eq($sformatf("vec%0d_errs", v), obs_err, tbl[v].exp_errs);
            if (tbl[v].exp_reports > 0)
                expect_eq($sformatf("vec%0d_value", v), int'(obs_value), int'(tbl[v].exp_value));
            $display("vec%0d seg=%b hold=%0d: reports=%0d errs=%0d value=%h",
                     v, tbl[v].pat, tbl[v].hold_cycles, obs_valid, obs_err, obs_value);
        end

        // Full holding register: second result is dropped and flagged.
        hold(7'b0001101, 8, 1'b0);
        hold(BLANK, 8, 1'b0);
        hold(7'b0110000, 8, 1'b0);
        hold(BLANK, 3, 1'b0);
        expect_eq("ovr_held_value", int'(value), 7);
        expect_eq("ovr_held_valid", int'(out_valid), 1);
        expect_eq("ovr_flag_set", int'(overrun), 1);
        step(BLANK, 1'b1, 1'b0);
        expect_eq("ovr_drain_valid", int'(out_valid), 0);
        expect_eq("ovr_sticky", int'(overrun), 1);
        step(BLANK, 1'b0, 1'b1);
        expect_eq("ovr_cleared", int'(overrun), 0);
        $display("overrun sequence: value=%h valid=%b overrun=%b", value, out_valid, overrun);

        // Reset while A is pending, then release onto a steady 1.
        hold(7'b0001000, 8, 1'b0);
        expect_eq("pending_A_valid", int'(out_valid), 1);
        expect_eq("pending_A_value", int'(value), 10);
        do_reset(7'b1001111);
        latency_run(7'b1001111, "after_reset1", 1);

        // Random patterns with random handshake and clear activity.
        for (int n = 0; n < 1200; n++) begin
            logic [6:0] pat;
            int         r;
            int         len;
            r   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 8));
            if (r <= 5)      pat = code_tab[$urandom_range(0, 15)];
            else if (r <= 7) pat = BLANK;
            else             pat = 7'($urandom);
            for (int k = 0; k < len; k++)
                step(pat, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        $display("random phase done: %0d checks so far", checks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Inverse of the team's 7-segment display decoder: samples an active-low a–g segment bus from an external or multiplexed display source and recovers the 4-bit hex nibble it shows. Qualifies a pattern only after it has been stable for a programmable number of cycles, reports it once per stable occurrence over a valid/ready handshake, flags unrecognised patterns and flags lost results. Sits between segment-level stimulus (board pins, display snoop, loopback from the decoder) and nibble-level logic.

## Interface
- STABLE_CYCLES, default 4: consecutive equal samples required to qualify a pattern. Legal range is 1 and above.
- clk  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- seg  in  7  `[0:6]`, asynchronous to `clk`. `seg[0]` = a … `seg[6]` = g. Active-low: 0 means the segment is lit.
- value  out  4  decoded nibble, held while `out_valid` is high.
- out_valid  out  1  `value` holds an unconsumed result.
- out_ready  in  1  consumer accepts `value`.
- err  out  1  one-cycle pulse: a stable pattern is neither a legal code nor blank.
- overrun  out  1  sticky: a result was lost because the holding register was full.
- ovr_clr  in  1  synchronous clear of `overrun`.

## Operation
- Code table, written a..g as `seg[0]`..`seg[6]`:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001101
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Blank = 1111111.
- Synchronizer: two flops on `seg`. Both reset to 1111111. The second stage is `seg_s`.
- `last`: register holding the previous `seg_s`. Resets to 1111111.
- `cnt`: saturating counter of width clog2(STABLE_CYCLES+1).
  - Clears to 0 when `seg_s` != `last`.
  - Otherwise increments, saturating at STABLE_CYCLES.
- `qualify` (combinational) is true when `seg_s` == `last`, `cnt` == STABLE_CYCLES−1 and the FSM is in TRACK.
- FSM, two states; reset state is TRACK.
  - TRACK → LOCKED on `qualify`. The action on that edge depends on the pattern:
    - Legal code: result is offered to the holding register.
    - Blank: no output and no error.
    - Anything else: `err`=1 for that one cycle.
  - LOCKED → TRACK when `seg_s` != `last`. No re-report while the pattern is unchanged.
- Holding register (`value`, `out_valid`):
  - A transfer occurs on a cycle where `out_valid` && `out_ready`.
  - Offer with `out_valid`=0, or offer together with a transfer: load `value`; `out_valid`=1 next cycle.
  - Transfer with no offer: `out_valid`=0 next cycle.
  - Offer while `out_valid`=1 and `out_ready`=0: keep the old `value`, discard the new one, set `overrun`=1.
- `overrun` clears on `ovr_clr`. If a set and `ovr_clr` occur in the same cycle, the set wins.

## Timing
- Reset values: `value`=0, `out_valid`=0, `err`=0, `overrun`=0, `cnt`=0, state TRACK.
- Assertion of `rst_n`=0 forces these values immediately (asynchronous), including mid-handshake. A pending result is lost and not flagged.
- Latency: count edge 1 as the first rising edge that samples a new, steady pattern P on `seg`.
  - `out_valid` (or `err`) rises after edge STABLE_CYCLES+3.
  - Examples: 7 edges for STABLE_CYCLES=4; 4 edges for STABLE_CYCLES=1.
- A change of `seg` of any length before qualification restarts the count; only a pattern held for the full window is reported.
- `value` is stable for the whole time `out_valid`=1.
- `out_valid` may rise without depending on `out_ready`.
- Back-to-back results: the maximum rate is one qualification per STABLE_CYCLES+1 cycles. A consumer holding `out_ready`=1 never sees `overrun`.
- After a transfer with no new offer, `out_valid` drops on the next edge.
- `err` is exactly one cycle wide. `err` and `out_valid` never rise from the same qualification.

## Test plan
- Reset, then `seg`=0000110 held; STABLE_CYCLES=4; `out_ready`=1. Expect: `out_valid` high for exactly one cycle after edge 7 with `value`=3, and no further report while `seg` stays at 0000110.
- Sweep all 16 codes, each held 10 cycles, with `out_ready`=1. Expect: values 0..F reported in order; `err`=0 throughout; blank 1111111 inserted between codes is never reported.
- `seg`=1010101 held. Expect: one `err` pulse after edge 7, `out_valid` stays 0. Glitch `seg`=0100100 for 2 cycles then 1111111. Expect: no report.
- `out_ready`=0; present 7 (0001101), then blank, then E (0110000). Expect: `value`=7 held, `overrun`=1 after E qualifies. Raise `out_ready`. Expect: 7 accepted, `out_valid`=0. Pulse `ovr_clr`. Expect: `overrun`=0.
- Assert `rst_n`=0 while `out_valid`=1 with `value`=A. Expect: `out_valid`=0, `value`=0 before the next edge. Release with `seg` steady at 1001111. Expect: report `value`=1 after edge STABLE_CYCLES+3.
